// File: rtl/leve1_pkg.sv
// rtl/leve1_pkg.sv - shared constants and entry type for the LEVE1 fetch front end
package leve1_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [31:0]         instr;
        logic                err;
    } fetch_entry_t;

endpackage

// File: rtl/leve1_fetch_queue_if.sv
// rtl/leve1_fetch_queue_if.sv - redirect, instruction read channel and decode handshake bundle
interface leve1_fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            IPC_WE;
    logic [XLEN-1:0] INEXT_PC;
    logic            ARVALID;
    logic            ARREADY;
    logic [XLEN-1:0] ARADDR;
    logic            RVALID;
    logic            RREADY;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            OVALID;
    logic            OREADY;
    logic [XLEN-1:0] OPC;
    logic [31:0]     OINSTR;
    logic            OERR;

    modport master (
        input  IPC_WE, INEXT_PC, ARREADY, RVALID, RDATA, RRESP, OREADY,
        output ARVALID, ARADDR, RREADY, OVALID, OPC, OINSTR, OERR
    );

    modport slave (
        output IPC_WE, INEXT_PC, ARREADY, RVALID, RDATA, RRESP, OREADY,
        input  ARVALID, ARADDR, RREADY, OVALID, OPC, OINSTR, OERR
    );
endinterface

// File: rtl/leve1_sync_fifo.sv
// rtl/leve1_sync_fifo.sv - synchronous FIFO with flush and occupancy count
module leve1_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & ~flush & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/leve1_fetch_queue.sv
// rtl/leve1_fetch_queue.sv - LEVE1 fetch PC, credit-limited read issue and tagged instruction queue
// Optional feature macro: LEVE1_FETCH_ERR_EN (per-entry read fault flag and issue stop)
module leve1_fetch_queue
    import leve1_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    leve1_fetch_queue_if.master     io
);
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef LEVE1_FETCH_ERR_EN
    localparam int EW = XLEN + 32 + 1;
`else
    localparam int EW = XLEN + 32;
`endif
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_tag;
    logic [XLEN-1:0] araddr_q;
    logic            arvalid_q;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;

    logic [CW-1:0]   outstanding_n;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   count_n;
    logic [CW:0]     occupancy_n;
    logic            fifo_empty;
    logic            redirect;
    logic            ar_hs;
    logic            ar_held;
    logic            r_hs;
    logic            push;
    logic            pop;
    logic            credit;
    logic            launch;
    logic            stop_n;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_base;
    logic [EW-1:0]   push_data;
    logic [EW-1:0]   head;

    assign redirect = io.IPC_WE;
    assign target   = {io.INEXT_PC[XLEN-1:2], 2'b00};
    assign ar_hs    = arvalid_q & io.ARREADY;
    assign ar_held  = arvalid_q & ~io.ARREADY;
    // Every accepted beat already owns a FIFO slot, so the R channel never stalls.
    assign r_hs     = io.RVALID;
    assign push     = r_hs & ~redirect & (discard == '0);
    assign pop      = ~fifo_empty & io.OREADY & ~redirect;

    assign outstanding_n = outstanding + CW'(ar_hs) - CW'(r_hs);
    assign count_n       = redirect ? '0 : (fifo_count + CW'(push) - CW'(pop));
    assign occupancy_n   = {1'b0, outstanding_n} + {1'b0, count_n};
    assign credit        = (occupancy_n < DEPTH_W);
    // A held request keeps its address; the next launch picks up any redirect target.
    assign launch        = ~ar_held & credit & ~stop_n;
    assign pc_base       = redirect ? target : fetch_pc;

`ifdef LEVE1_FETCH_ERR_EN
    logic stop_q;
    logic resp_err;

    assign resp_err  = (io.RRESP != RESP_OKAY);
    assign push_data = {pc_tag, io.RDATA, resp_err};
    // Issue freezes once a faulted word is queued, until execute redirects.
    assign stop_n    = ~redirect & (stop_q | (push & resp_err));
    assign io.OERR   = ~fifo_empty & head[0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            stop_q <= 1'b0;
        end else begin
            stop_q <= stop_n;
        end
    end
`else
    logic unused_resp;

    assign unused_resp = ^io.RRESP;
    assign push_data   = {pc_tag, io.RDATA};
    assign stop_n      = 1'b0;
    assign io.OERR     = 1'b0;
`endif

    leve1_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .flush (redirect),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign io.ARVALID = arvalid_q;
    assign io.ARADDR  = araddr_q;
    assign io.RREADY  = 1'b1;
    assign io.OVALID  = ~fifo_empty;
    assign io.OPC     = fifo_empty ? '0 : head[EW-1 -: XLEN];
    assign io.OINSTR  = fifo_empty ? '0 : head[EW-XLEN-1 -: 32];

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc    <= RESET_PC;
            araddr_q    <= RESET_PC;
            arvalid_q   <= 1'b0;
            pc_tag      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            arvalid_q   <= ar_held | launch;
            outstanding <= outstanding_n;

            if (launch) begin
                araddr_q <= pc_base;
                fetch_pc <= pc_base + XLEN'(PC_STEP);
            end else if (redirect) begin
                fetch_pc <= target;
            end

            // Everything in flight, plus a request still waiting on ARREADY, belongs to the old stream.
            if (redirect) begin
                discard <= outstanding_n + CW'(ar_held);
            end else if (r_hs && (discard != '0)) begin
                discard <= discard - 1'b1;
            end

            if (redirect) begin
                pc_tag <= target;
            end else if (push) begin
                pc_tag <= pc_tag + XLEN'(PC_STEP);
            end
        end
    end

endmodule

// File: tb/tb_leve1_fetch_queue.sv
// tb/tb_leve1_fetch_queue.sv - scoreboard bench for leve1_fetch_queue with a latency-configurable memory
module tb_leve1_fetch_queue;
    import leve1_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          ready_cyc;
        bit          live;
    } mreq_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    leve1_fetch_queue_if #(.XLEN(32)) bus ();

    leve1_fetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .io  (bus)
    );

    always #5 CLK = ~CLK;

    mreq_t        memq[$];
    fetch_entry_t expq[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops  = 0;
    int lat_k = 1;
    bit rst_k = 1'b1;
    bit ar_ready_k = 1'b0;
    bit o_ready_k  = 1'b0;
    bit redir_k    = 1'b0;
    bit collide_k  = 1'b0;
    bit collided   = 1'b0;
    bit held_redir = 1'b0;
    bit ar_dead    = 1'b0;
    logic [31:0] redir_tgt = '0;
    logic [31:0] err_addr  = 32'hFFFF_FFFF;
    logic [31:0] next_addr = RESET_PC;
    logic [31:0] held_tgt  = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
    endfunction

    // One clock of stimulus: drive at negedge, then account for the handshakes of the coming posedge.
    task automatic step();
        mreq_t        m;
        fetch_entry_t e;
        bit           r_hs;
        bit           ar_hs;
        bit           pop;
        @(negedge CLK);
        cyc++;
        RST          = rst_k;
        bus.RVALID   = 1'b0;
        bus.RDATA    = '0;
        bus.RRESP    = 2'b00;
        if (!rst_k && memq.size() > 0 && memq[0].ready_cyc <= cyc) begin
            bus.RVALID = 1'b1;
            bus.RDATA  = mem_word(memq[0].addr);
            bus.RRESP  = (memq[0].addr == err_addr) ? 2'b10 : 2'b00;
        end
        bus.ARREADY  = ar_ready_k;
        bus.OREADY   = o_ready_k;
        bus.INEXT_PC = redir_tgt;
        bus.IPC_WE   = redir_k;
        if (collide_k && bus.RVALID && bus.OVALID && o_ready_k) begin
            bus.IPC_WE = 1'b1;
            collide_k  = 1'b0;
            collided   = 1'b1;
        end
        redir_k = 1'b0;

        if (rst_k) begin
            memq.delete();
            expq.delete();
            next_addr  = RESET_PC;
            held_redir = 1'b0;
            ar_dead    = 1'b0;
        end else begin
            r_hs  = bus.RVALID;
            ar_hs = bus.ARVALID && bus.ARREADY;
            pop   = bus.OVALID && bus.OREADY && !bus.IPC_WE;
            if (pop) begin
                total++;
                pops++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected got opc=%h instr=%h, required no valid", bus.OPC, bus.OINSTR);
                end else begin
                    e = expq.pop_front();
                    if (bus.OPC !== e.pc || bus.OINSTR !== e.instr || bus.OERR !== e.err) begin
                        bad++;
                        $display("FAIL pop_data got pc=%h instr=%h err=%b, required pc=%h instr=%h err=%b",
                                 bus.OPC, bus.OINSTR, bus.OERR, e.pc, e.instr, e.err);
                    end
                end
            end
            if (r_hs) begin
                m = memq.pop_front();
                if (m.live && !bus.IPC_WE) begin
                    e.pc    = m.addr;
                    e.instr = mem_word(m.addr);
`ifdef LEVE1_FETCH_ERR_EN
                    e.err   = (bus.RRESP != 2'b00);
`else
                    e.err   = 1'b0;
`endif
                    expq.push_back(e);
                end
            end
            if (ar_hs) begin
                total++;
                if (bus.ARADDR !== next_addr) begin
                    bad++;
                    $display("FAIL araddr got %h, required %h", bus.ARADDR, next_addr);
                end
                m.addr      = bus.ARADDR;
                m.ready_cyc = cyc + lat_k;
                m.live      = !bus.IPC_WE && !ar_dead;
                memq.push_back(m);
                ar_dead = 1'b0;
                if (held_redir) begin
                    next_addr  = held_tgt;
                    held_redir = 1'b0;
                end else begin
                    next_addr = next_addr + 32'd4;
                end
            end
            if (bus.IPC_WE) begin
                foreach (memq[i]) memq[i].live = 1'b0;
                expq.delete();
                if (bus.ARVALID && !ar_hs) begin
                    ar_dead    = 1'b1;
                    held_redir = 1'b1;
                    held_tgt   = redir_tgt & ~32'd3;
                end else begin
                    next_addr  = redir_tgt & ~32'd3;
                    held_redir = 1'b0;
                end
            end
            total++;
            if (memq.size() > DEPTH) begin
                bad++;
                $display("FAIL outstanding got %0d, required <= %0d", memq.size(), DEPTH);
            end
        end
    endtask

    task automatic test_reset();
        rst_k = 1'b1; ar_ready_k = 1'b0; o_ready_k = 1'b0;
        repeat (3) step();
        total += 6;
        if (bus.ARVALID !== 1'b0) begin bad++; $display("FAIL reset_arvalid got %b, required 0", bus.ARVALID); end
        if (bus.OVALID !== 1'b0)  begin bad++; $display("FAIL reset_ovalid got %b, required 0", bus.OVALID); end
        if (bus.RREADY !== 1'b1)  begin bad++; $display("FAIL reset_rready got %b, required 1", bus.RREADY); end
        if (bus.OPC !== 32'h0)    begin bad++; $display("FAIL reset_opc got %h, required 0", bus.OPC); end
        if (bus.OINSTR !== 32'h0) begin bad++; $display("FAIL reset_oinstr got %h, required 0", bus.OINSTR); end
        if (bus.OERR !== 1'b0)    begin bad++; $display("FAIL reset_oerr got %b, required 0", bus.OERR); end
        rst_k = 1'b0;
    endtask

    task automatic test_backpressure();
        lat_k = 1; ar_ready_k = 1'b1; o_ready_k = 1'b0;
        repeat (10) step();
        total += 5;
        if (bus.ARVALID !== 1'b0) begin bad++; $display("FAIL bp_arvalid got %b, required 0", bus.ARVALID); end
        if (expq.size() != DEPTH) begin bad++; $display("FAIL bp_fill got %0d entries, required %0d", expq.size(), DEPTH); end
        if (memq.size() != 0)     begin bad++; $display("FAIL bp_inflight got %0d, required 0", memq.size()); end
        if (bus.OPC !== 32'h0)    begin bad++; $display("FAIL bp_head_pc got %h, required 0", bus.OPC); end
        if (bus.OINSTR !== mem_word(32'h0)) begin
            bad++; $display("FAIL bp_head_instr got %h, required %h", bus.OINSTR, mem_word(32'h0));
        end
        o_ready_k = 1'b1;
        repeat (12) step();
        total++;
        if (next_addr <= 32'h10) begin bad++; $display("FAIL bp_resume next request %h, required beyond 0x10", next_addr); end
    endtask

    task automatic test_stream();
        int p0;
        p0 = pops;
        lat_k = 1; ar_ready_k = 1'b1; o_ready_k = 1'b1;
        repeat (40) step();
        lat_k = 3;
        repeat (40) step();
        total++;
        if (pops - p0 < 40) begin bad++; $display("FAIL stream_throughput got %0d pops, required >= 40", pops - p0); end
    endtask

    task automatic test_redirect();
        int i;
        lat_k = 4; ar_ready_k = 1'b1; o_ready_k = 1'b1;
        for (i = 0; i < 50 && memq.size() < 3; i++) step();
        total++;
        if (memq.size() < 3) begin bad++; $display("FAIL redir_setup got %0d in flight, required 3", memq.size()); end
        redir_tgt = 32'h103; redir_k = 1'b1;
        step();
        step();
        total++;
        if (bus.OVALID !== 1'b0) begin bad++; $display("FAIL redir_ovalid got %b, required 0", bus.OVALID); end
        for (i = 0; i < 60 && bus.OVALID !== 1'b1; i++) step();
        total += 2;
        if (bus.OPC !== 32'h100) begin bad++; $display("FAIL redir_opc got %h, required 100", bus.OPC); end
        if (bus.OINSTR !== mem_word(32'h100)) begin
            bad++; $display("FAIL redir_instr got %h, required %h", bus.OINSTR, mem_word(32'h100));
        end
        repeat (10) step();
    endtask

    task automatic test_back_to_back();
        int i;
        lat_k = 3; ar_ready_k = 1'b1; o_ready_k = 1'b1;
        repeat (6) step();
        redir_tgt = 32'h500; redir_k = 1'b1;
        step();
        redir_tgt = 32'h604; redir_k = 1'b1;
        step();
        for (i = 0; i < 60 && bus.OVALID !== 1'b1; i++) step();
        total++;
        if (bus.OPC !== 32'h604) begin bad++; $display("FAIL b2b_opc got %h, required 604", bus.OPC); end
        repeat (10) step();
    endtask

    task automatic test_held_redirect();
        int i;
        logic [31:0] a0;
        lat_k = 1; o_ready_k = 1'b1; ar_ready_k = 1'b0;
        step();
        for (i = 0; i < 20 && bus.ARVALID !== 1'b1; i++) step();
        a0 = bus.ARADDR;
        redir_tgt = 32'h200; redir_k = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (bus.ARVALID !== 1'b1 || bus.ARADDR !== a0) begin
                bad++; $display("FAIL held_ar got valid=%b addr=%h, required valid=1 addr=%h", bus.ARVALID, bus.ARADDR, a0);
            end
        end
        ar_ready_k = 1'b1;
        for (i = 0; i < 40 && bus.OVALID !== 1'b1; i++) step();
        total++;
        if (bus.OPC !== 32'h200) begin bad++; $display("FAIL held_opc got %h, required 200", bus.OPC); end
        repeat (10) step();
    endtask

    task automatic test_collision();
        int i;
        lat_k = 2; ar_ready_k = 1'b1; o_ready_k = 1'b1;
        redir_tgt = 32'h300; collided = 1'b0; collide_k = 1'b1;
        for (i = 0; i < 50 && !collided; i++) step();
        collide_k = 1'b0;
        total++;
        if (!collided) begin bad++; $display("FAIL collide_setup got no coincident beat, required one"); end
        step();
        total++;
        if (bus.OVALID !== 1'b0) begin bad++; $display("FAIL collide_ovalid got %b, required 0", bus.OVALID); end
        for (i = 0; i < 40 && bus.OVALID !== 1'b1; i++) step();
        total++;
        if (bus.OPC !== 32'h300) begin bad++; $display("FAIL collide_opc got %h, required 300", bus.OPC); end
        repeat (10) step();
    endtask

`ifdef LEVE1_FETCH_ERR_EN
    task automatic test_err();
        int i;
        lat_k = 1; ar_ready_k = 1'b1; o_ready_k = 1'b1;
        err_addr = 32'h8; redir_tgt = 32'h0; redir_k = 1'b1;
        step();
        for (i = 0; i < 40 && !(bus.OVALID === 1'b1 && bus.OPC === 32'h8); i++) step();
        total++;
        if (bus.OERR !== 1'b1 || bus.OPC !== 32'h8) begin
            bad++; $display("FAIL err_flag got pc=%h oerr=%b, required pc=8 oerr=1", bus.OPC, bus.OERR);
        end
        repeat (20) step();
        total += 2;
        if (bus.ARVALID !== 1'b0) begin bad++; $display("FAIL err_stop got arvalid=%b, required 0", bus.ARVALID); end
        if (memq.size() != 0) begin bad++; $display("FAIL err_inflight got %0d, required 0", memq.size()); end
        err_addr = 32'hFFFF_FFFF; redir_tgt = 32'h40; redir_k = 1'b1;
        step();
        for (i = 0; i < 20 && bus.ARVALID !== 1'b1; i++) step();
        total++;
        if (bus.ARVALID !== 1'b1 || bus.ARADDR !== 32'h40) begin
            bad++; $display("FAIL err_resume got valid=%b addr=%h, required valid=1 addr=40", bus.ARVALID, bus.ARADDR);
        end
        repeat (10) step();
    endtask
`else
    task automatic test_resp_ignored();
        lat_k = 1; ar_ready_k = 1'b1; o_ready_k = 1'b1;
        err_addr = 32'h8; redir_tgt = 32'h0; redir_k = 1'b1;
        repeat (20) step();
        total++;
        if (bus.ARVALID !== 1'b1) begin bad++; $display("FAIL resp_ignored got arvalid=%b, required 1", bus.ARVALID); end
        err_addr = 32'hFFFF_FFFF;
        repeat (5) step();
    endtask
`endif

    task automatic test_drain();
        ar_ready_k = 1'b0; o_ready_k = 1'b1;
        repeat (12) step();
        total++;
        if (expq.size() != 0 || memq.size() != 0) begin
            bad++; $display("FAIL drain got %0d queued %0d in flight, required 0 and 0", expq.size(), memq.size());
        end
    endtask

    initial begin
        bus.IPC_WE = 1'b0; bus.INEXT_PC = '0; bus.ARREADY = 1'b0; bus.RVALID = 1'b0;
        bus.RDATA = '0; bus.RRESP = 2'b00; bus.OREADY = 1'b0;
        test_reset();
        test_backpressure();
        test_stream();
        test_redirect();
        test_back_to_back();
        test_held_redirect();
        test_collision();
`ifdef LEVE1_FETCH_ERR_EN
        test_err();
`else
        test_resp_ignored();
`endif
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/leve1_fetch_queue.md
Name: leve1_fetch_queue

Overview:
Instruction fetch front end for the LEVE1 pipeline, sitting directly upstream of the decode stage. Keeps the fetch PC and issues read-address requests on the instruction read channel, up to DEPTH outstanding. Buffers returned instructions, tagged with their PC, in a small FIFO. Presents them to decode with a valid/ready handshake, and drops in-flight fetches on a redirect from execute.

Parameters:
XLEN, 32, address/PC width (matches `XLEN of defs.vh)
DEPTH, 4, FIFO entries and maximum outstanding reads (power of two, >=2)
RESET_PC, 32'h0000_0000, PC fetched first after reset

Ports:
CLK  in  1  clock; all logic rising-edge
RST  in  1  synchronous reset, active-high
IPC_WE  in  1  redirect request from execute
INEXT_PC  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
ARVALID  out  1  read address valid
ARREADY  in  1  read address ready
ARADDR  out  XLEN  read address (word aligned)
RVALID  in  1  read data valid
RREADY  out  1  read data ready
RDATA  in  32  instruction word
RRESP  in  2  read response (00 OKAY)
OVALID  out  1  instruction valid to decode
OREADY  in  1  decode accepts
OPC  out  XLEN  PC of presented instruction
OINSTR  out  32  presented instruction
OERR  out  1  fetch fault flag (only with LEVE1_FETCH_ERR_EN, else tied 0)

Behaviour:
- Clock and reset: one clock (CLK). Reset RST is synchronous and active-high. Reset forces fetch_pc=RESET_PC, ARVALID=0, RREADY=1, FIFO empty (OVALID=0), outstanding=0, discard=0. OPC and OINSTR are 0 on reset. Reset asserted mid-transaction abandons all state; the interconnect is reset together.
- Credit: issue allowed when outstanding + fifo_count < DEPTH. This guarantees every accepted beat has a FIFO slot, so RREADY stays 1 always.
- AR channel:
  - ARVALID rises the cycle after credit is available. ARADDR = fetch_pc.
  - On ARVALID&ARREADY: fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding++.
  - Once asserted, ARVALID and ARADDR hold until handshake, even across a redirect.
- R channel: on RVALID, outstanding--.
  - If discard>0: discard--, beat dropped.
  - Else push {pc_tag, RDATA, RRESP!=0} to the FIFO, then pc_tag += 4.
  - pc_tag tracks the PC of the next expected response.
- Output: OVALID = FIFO non-empty; OPC/OINSTR come from the FIFO head. Pop on OVALID&OREADY. Push and pop in the same cycle are allowed, including when full (count unchanged) and when empty-with-push (data visible next cycle; no bypass). Minimum latency from ARVALID&ARREADY with a same-cycle response is 1 cycle to OVALID.
- Redirect (IPC_WE=1), same cycle:
  - FIFO flushed; OVALID=0 next cycle; OREADY ignored this cycle.
  - discard <= outstanding_next + (ARVALID pending & not accepted this cycle ? 1 : 0), where outstanding_next counts the handshakes/responses of this cycle. Any R beat in the redirect cycle is dropped.
  - fetch_pc <= INEXT_PC & ~3 and pc_tag <= INEXT_PC & ~3. If ARVALID is held unaccepted, the new fetch_pc is used after that handshake completes.
  - New requests may issue while discard>0, subject to credit; the credit count includes discard entries.
- Back-to-back redirects: discard accumulates correctly; the last target wins.
- Counter widths: outstanding and discard are $clog2(DEPTH)+1 bits. Neither may overflow, by construction.

Optional Feature:
LEVE1_FETCH_ERR_EN:
- Defined: RRESP!=OKAY is stored per entry and driven on OERR with the instruction. After pushing an errored entry, the block stops issuing until the next IPC_WE, so execute can raise an access fault.
- Undefined: RRESP is ignored, OERR is tied 0, and the FIFO entry omits the error bit.

Decomposition:
- leve1_pkg: RESP_OKAY constant, fetch_entry_t struct {pc, instr, err}, PC_STEP=4.
- Sub-module leve1_sync_fifo (parameterised width/depth, push/pop/flush, count output) holds the entries. Credit, PC and discard logic stay in leve1_fetch_queue.

Test Plan:
- Reset then ARREADY=1, 1-cycle memory, OREADY=1 -> ARADDR 0,4,8,...; OPC/OINSTR stream in order; at most 4 outstanding.
- OREADY=0 for 10 cycles -> FIFO fills to 4, ARVALID drops, no beat lost. Restore OREADY -> 4 pops in order (PC 0,4,8,12), then fetch resumes at 16.
- 3 reads outstanding, IPC_WE with INEXT_PC=0x103 -> 3 beats dropped; next OPC=0x100 with the instruction from 0x100.
- ARVALID held with ARREADY=0 while IPC_WE=1 to 0x200 -> ARADDR unchanged until handshake; that response dropped; next request is 0x200.
- Redirect coincident with RVALID and OREADY -> no pop counted; beat dropped; OVALID=0 next cycle.
- With LEVE1_FETCH_ERR_EN: RRESP=2 on 0x8 -> OERR=1 at OPC=0x8, no further ARVALID until IPC_WE.
